gshare_branch_predictor: RTL and testbench

- Parametrised direction predictor for the fetch stage.
- Holds a flop-based pattern history table (PHT) of saturating counters, indexed by PC hashed with a speculative global history register (GHR).
- Answers one lookup per cycle with fixed 1-cycle latency and returns the GHR checkpoint with each prediction.
- The commit/control side trains counters and, on mispredict, restores the GHR from that checkpoint.

---
 rtl/gshare_branch_predictor.sv | 140 ++++++++++++++
 tb/tb_gshare_branch_predictor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/gshare_branch_predictor.sv
// gshare direction predictor for the fetch stage.
//
// A flop-based pattern history table (PHT) of saturating counters is indexed by
// the fetch PC hashed with a speculative global history register (GHR). One
// lookup is accepted per cycle and answered one cycle later. Each response
// carries the GHR value that was in place before the prediction, so the control
// side can hand it back on a mispredict and rebuild the history.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_*           lookup request (valid/ready, PC, instruction word)
//   resp_*          registered prediction: branch flag, direction, next PC,
//                   counter read, PHT index, GHR checkpoint, instruction copy
//   upd_*           training (idx/taken) and GHR restore (mispredict/ghr)
//   mispredict_cnt  saturating count of mispredict updates
module gshare_branch_predictor #(
  parameter int unsigned GHR_LEN     = 8,
  parameter int unsigned PHT_IDX_LEN = 10,
  parameter int unsigned CTR_W       = 2,
  parameter int unsigned HASH_MODE   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [31:0]            req_pc,
  input  logic [31:0]            req_instr,
  output logic                   resp_valid,
  output logic                   resp_is_br,
  output logic                   resp_taken,
  output logic [31:0]            resp_target,
  output logic [CTR_W-1:0]       resp_ctr,
  output logic [PHT_IDX_LEN-1:0] resp_idx,
  output logic [GHR_LEN-1:0]     resp_ghr,
  output logic [31:0]            resp_instr,
  input  logic                   upd_valid,
  input  logic [PHT_IDX_LEN-1:0] upd_idx,
  input  logic                   upd_taken,
  input  logic                   upd_mispredict,
  input  logic [GHR_LEN-1:0]     upd_ghr,
  output logic [31:0]            mispredict_cnt
);

  localparam int unsigned      Depth    = 2 ** PHT_IDX_LEN;
  localparam logic [CTR_W-1:0] CtrInit  = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CTR_W-1:0] CtrMax   = '1;
  localparam logic [6:0]       OpBranch = 7'b1100011;

  // Shift a new outcome into the youngest history position.
  function automatic logic [GHR_LEN-1:0] shift_in(input logic [GHR_LEN-1:0] hist,
                                                  input logic bit_in);
    return GHR_LEN'({hist, bit_in});
  endfunction

  logic [CTR_W-1:0]       pht_q [Depth];
  logic [GHR_LEN-1:0]     ghr_q, ghr_d;
  logic [PHT_IDX_LEN-1:0] lookup_idx;
  logic [CTR_W-1:0]       upd_ctr_cur, upd_ctr_new, rd_ctr;
  logic                   restore, accept, is_br, pred_taken;
  logic [31:0]            b_imm, target;

  assign restore   = upd_valid & upd_mispredict;
  assign req_ready = ~restore;
  assign accept    = req_valid & req_ready;

  if (HASH_MODE == 0) begin : g_concat
    assign lookup_idx = {ghr_q, req_pc[PHT_IDX_LEN-GHR_LEN+1:2]};
  end else begin : g_xor
    assign lookup_idx = req_pc[PHT_IDX_LEN+1:2] ^ PHT_IDX_LEN'(ghr_q);
  end

  assign upd_ctr_cur = pht_q[upd_idx];

  always_comb begin
    upd_ctr_new = upd_ctr_cur;
    if (upd_taken) begin
      if (upd_ctr_cur != CtrMax) upd_ctr_new = upd_ctr_cur + CTR_W'(1);
    end else if (upd_ctr_cur != '0) begin
      upd_ctr_new = upd_ctr_cur - CTR_W'(1);
    end
  end

  // Write-first: a same-cycle update to the looked-up entry is forwarded.
  assign rd_ctr = (upd_valid && (upd_idx == lookup_idx)) ? upd_ctr_new : pht_q[lookup_idx];

  assign is_br      = (req_instr[6:0] == OpBranch);
  assign pred_taken = is_br & rd_ctr[CTR_W-1];
  assign b_imm      = {{19{req_instr[31]}}, req_instr[31], req_instr[7], req_instr[30:25],
                       req_instr[11:8], 1'b0};
  assign target     = req_pc + (pred_taken ? b_imm : 32'd4);

  // Restore wins over the speculative shift; no request is accepted then anyway.
  always_comb begin
    ghr_d = ghr_q;
    if (restore) begin
      ghr_d = shift_in(upd_ghr, upd_taken);
    end else if (accept && is_br) begin
      ghr_d = shift_in(ghr_q, pred_taken);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(Depth); i++) pht_q[i] <= CtrInit;
    end else if (upd_valid) begin
      pht_q[upd_idx] <= upd_ctr_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q          <= '0;
      mispredict_cnt <= '0;
      resp_valid     <= 1'b0;
      resp_is_br     <= 1'b0;
      resp_taken     <= 1'b0;
      resp_target    <= '0;
      resp_ctr       <= '0;
      resp_idx       <= '0;
      resp_ghr       <= '0;
      resp_instr     <= '0;
    end else begin
      ghr_q      <= ghr_d;
      resp_valid <= accept;
      if (restore && (mispredict_cnt != 32'hFFFF_FFFF)) begin
        mispredict_cnt <= mispredict_cnt + 32'd1;
      end
      if (accept) begin
        resp_is_br  <= is_br;
        resp_taken  <= pred_taken;
        resp_target <= target;
        resp_ctr    <= is_br ? rd_ctr : '0;
        resp_idx    <= lookup_idx;
        resp_ghr    <= ghr_q;
        resp_instr  <= req_instr;
      end
    end
  end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed bench for gshare_branch_predictor at default parameters
// (GHR_LEN 8, PHT_IDX_LEN 10, CTR_W 2, xor hashing).
module tb_gshare_branch_predictor;

  localparam logic [31:0] Beq  = 32'h0000_0863;  // beq, imm +16
  localparam logic [31:0] Addi = 32'h0010_0093;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_pc, req_instr;
  logic        resp_valid, resp_is_br, resp_taken;
  logic [31:0] resp_target, resp_instr;
  logic [1:0]  resp_ctr;
  logic [9:0]  resp_idx;
  logic [7:0]  resp_ghr;
  logic        upd_valid, upd_taken, upd_mispredict;
  logic [9:0]  upd_idx;
  logic [7:0]  upd_ghr;
  logic [31:0] mispredict_cnt;

  int unsigned total  = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  gshare_branch_predictor dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_pc         (req_pc),
    .req_instr      (req_instr),
    .resp_valid     (resp_valid),
    .resp_is_br     (resp_is_br),
    .resp_taken     (resp_taken),
    .resp_target    (resp_target),
    .resp_ctr       (resp_ctr),
    .resp_idx       (resp_idx),
    .resp_ghr       (resp_ghr),
    .resp_instr     (resp_instr),
    .upd_valid      (upd_valid),
    .upd_idx        (upd_idx),
    .upd_taken      (upd_taken),
    .upd_mispredict (upd_mispredict),
    .upd_ghr        (upd_ghr),
    .mispredict_cnt (mispredict_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic lookup(input logic [31:0] pc, input logic [31:0] instr);
    req_valid = 1'b1;
    req_pc    = pc;
    req_instr = instr;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic train(input logic [9:0] idx, input logic taken);
    upd_valid = 1'b1;
    upd_idx   = idx;
    upd_taken = taken;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic check_resp(input string tag, input logic br, input logic taken,
                            input logic [31:0] target, input logic [1:0] ctr,
                            input logic [9:0] idx, input logic [7:0] ghr);
    check({tag, ".valid"},  32'(resp_valid),  32'd1);
    check({tag, ".is_br"},  32'(resp_is_br),  32'(br));
    check({tag, ".taken"},  32'(resp_taken),  32'(taken));
    check({tag, ".target"}, resp_target,      target);
    check({tag, ".ctr"},    32'(resp_ctr),    32'(ctr));
    check({tag, ".idx"},    32'(resp_idx),    32'(idx));
    check({tag, ".ghr"},    32'(resp_ghr),    32'(ghr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    req_valid      = 1'b0;
    req_pc         = '0;
    req_instr      = '0;
    upd_valid      = 1'b0;
    upd_idx        = '0;
    upd_taken      = 1'b0;
    upd_mispredict = 1'b0;
    upd_ghr        = '0;
    tick();
    check("rst.ready", 32'(req_ready), 32'd1);
    tick();
    rst = 1'b0;
    check("rst.valid",  32'(resp_valid),  32'd0);
    check("rst.target", resp_target,      32'd0);
    check("rst.ghr",    32'(resp_ghr),    32'd0);
    check("rst.ctr",    32'(resp_ctr),    32'd0);
    check("rst.mcnt",   mispredict_cnt,   32'd0);

    // Cold branch: weakly not-taken, GHR shifts in 0.
    lookup(32'h1000, Beq);
    check_resp("cold", 1'b1, 1'b0, 32'h1004, 2'b01, 10'h000, 8'h00);
    check("cold.instr", resp_instr, Beq);
    tick();
    check("idle.valid", 32'(resp_valid), 32'd0);

    // Train to strongly taken, GHR then becomes 0x01.
    train(10'h000, 1'b1);
    train(10'h000, 1'b1);
    lookup(32'h1000, Beq);
    check_resp("taken", 1'b1, 1'b1, 32'h1010, 2'b11, 10'h000, 8'h00);
    lookup(32'h2000, Addi);
    check_resp("probe1", 1'b0, 1'b0, 32'h2004, 2'b00, 10'h001, 8'h01);

    // Saturate high, then walk down; PC chosen so idx stays 0 as GHR grows.
    train(10'h000, 1'b1);
    train(10'h000, 1'b1);
    lookup(32'h1004, Beq);
    check_resp("sat_hi", 1'b1, 1'b1, 32'h1014, 2'b11, 10'h000, 8'h01);
    train(10'h000, 1'b0);
    lookup(32'h100C, Beq);
    check_resp("dn1", 1'b1, 1'b1, 32'h101C, 2'b10, 10'h000, 8'h03);
    train(10'h000, 1'b0);
    lookup(32'h101C, Beq);
    check_resp("dn2", 1'b1, 1'b0, 32'h1020, 2'b01, 10'h000, 8'h07);
    train(10'h000, 1'b0);
    lookup(32'h1038, Beq);
    check_resp("dn3", 1'b1, 1'b0, 32'h103C, 2'b00, 10'h000, 8'h0E);
    train(10'h000, 1'b0);
    lookup(32'h1070, Beq);
    check_resp("sat_lo", 1'b1, 1'b0, 32'h1074, 2'b00, 10'h000, 8'h1C);

    // Restore with a competing request: request is refused.
    upd_valid      = 1'b1;
    upd_mispredict = 1'b1;
    upd_idx        = 10'h005;
    upd_taken      = 1'b1;
    upd_ghr        = 8'h5A;
    req_valid      = 1'b1;
    req_pc         = 32'h1000;
    req_instr      = Beq;
    #1;
    check("restore.ready", 32'(req_ready), 32'd0);
    tick();
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
    req_valid      = 1'b0;
    check("restore.valid", 32'(resp_valid), 32'd0);
    check("restore.mcnt",  mispredict_cnt,  32'd1);
    lookup(32'h2000, Addi);
    check_resp("probe2", 1'b0, 1'b0, 32'h2004, 2'b00, 10'h0B5, 8'hB5);

    // Same-cycle update and lookup on idx 0xB5: forwarded 01 -> 10.
    upd_valid = 1'b1;
    upd_idx   = 10'h0B5;
    upd_taken = 1'b1;
    lookup(32'h1000, Beq);
    upd_valid = 1'b0;
    check_resp("wfirst", 1'b1, 1'b1, 32'h1010, 2'b10, 10'h0B5, 8'hB5);

    lookup(32'h2000, Addi);
    check_resp("addi", 1'b0, 1'b0, 32'h2004, 2'b00, 10'h06B, 8'h6B);
    check("addi.instr", resp_instr, Addi);
    check("addi.mcnt",  mispredict_cnt, 32'd1);

    // Reset while a branch is offered and a response is in flight.
    rst       = 1'b1;
    req_valid = 1'b1;
    req_pc    = 32'h1000;
    req_instr = Beq;
    #1;
    check("rst2.ready", 32'(req_ready), 32'd1);
    tick();
    rst       = 1'b0;
    req_valid = 1'b0;
    check("rst2.valid",  32'(resp_valid), 32'd0);
    check("rst2.is_br",  32'(resp_is_br), 32'd0);
    check("rst2.target", resp_target,     32'd0);
    check("rst2.mcnt",   mispredict_cnt,  32'd0);
    lookup(32'h1000, Beq);
    check_resp("post0", 1'b1, 1'b0, 32'h1004, 2'b01, 10'h000, 8'h00);
    lookup(32'h12D4, Beq);
    check_resp("postB5", 1'b1, 1'b0, 32'h12D8, 2'b01, 10'h0B5, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
